seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle signed restoring divider: the inverse of the ALU add path. It
//  computes quotient/remainder by repeated shift-and-subtract, one bit/cycle.
//  Sits beside the ALU in the multdiv unit; the processor stalls on busy.
//  Each subtract step uses the RCA module with SIZE=WIDTH+1, cin=1, ~divisor.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
// PORTS
//  clock      in   1      single clock; all state updates on posedge
//  resetn     in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only in IDLE
//  dividend   in   WIDTH  signed two's-complement dividend, sampled with start
//  divisor    in   WIDTH  signed two's-complement divisor, sampled with start
//  busy       out  1      high in RUN and FIX states
//  ready      out  1      one-cycle pulse: results valid this cycle
//  quotient   out  WIDTH  signed quotient, truncated toward zero
//  remainder  out  WIDTH  signed remainder, sign follows dividend
//  exception  out  1      divide-by-zero flag, valid with ready
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, ready=0, exception=0, quotient=0, remainder=0.
//  Reset mid-operation aborts immediately; no ready is produced.
//  FSM: IDLE -> RUN on start (divisor!=0); IDLE -> DONE on start (divisor==0).
//   RUN: WIDTH iterations. 5-bit (clog2) counter 0..WIDTH-1; on last -> FIX.
//   FIX: apply signs (negate q if signs differ; negate r if dividend<0) -> DONE.
//   DONE: ready=1 for exactly one cycle -> IDLE.
//  Latency: start sampled at edge k. ready is high in the cycle after edge
//  k+WIDTH+2 for a nonzero divisor, and after edge k+1 for a zero divisor.
//  Iteration: {R,Q} <<= 1; T = R - |divisor| (WIDTH+1 bits).
//   If T >= 0: R=T, Q[0]=1. Else R unchanged, Q[0]=0.
//   Operands are made absolute at start. |MIN| is kept in WIDTH+1 bits, so
//   there is no magnitude overflow internally.
//  Outputs hold their last values until the next DONE, not just for one cycle.
//  start is ignored while busy or in DONE; operands are latched only at accept.
//  start asserted continuously in IDLE starts back-to-back operations.
//   The first cycle after DONE is IDLE and accepts a new start.
//  Divide-by-zero: exception=1, quotient=0, remainder=dividend.
//   exception clears on the next accepted start.
//  MIN/-1 (0x80000000 / 0xFFFFFFFF): quotient wraps to 0x80000000,
//   remainder=0, exception=0, unless the optional feature is enabled.
//  dividend=0 gives quotient=0, remainder=0.
//  |dividend| < |divisor| gives quotient=0, remainder=dividend.
// CONFIGURATION
//  DIV_OVERFLOW_EXC_EN defined:
//   MIN / -1 also sets exception=1 at ready; quotient=0x80000000, remainder=0.
//   Detected at accept; full-latency path is kept, so timing is unchanged.
//  DIV_OVERFLOW_EXC_EN undefined:
//   MIN / -1 wraps silently; exception only for divide-by-zero.
// TESTING (WIDTH=32)
//  100 / 7 -> after 34 cycles, ready pulse: q=14, r=2, exc=0.
//  -100 / 7 -> q=-14 (0xFFFFFFF2), r=-2; 100 / -7 -> q=-14, r=2.
//  123 / 0 -> ready on 2nd cycle after start; exc=1, q=0, r=123.
//   Next 8 / 2 -> exc=0, q=4.
//  0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
//   exc=0, or exc=1 with DIV_OVERFLOW_EXC_EN.
//  Start 1000/10, pulse start again at cycle 5 with 9/3 -> second start ignored;
//   q=100; busy stays high through FIX.
//  Start 50/5, drop resetn at cycle 10 -> all outputs 0, state IDLE.
//   No ready; then 9/3 -> q=3.

Source files
------------

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider -- multi-cycle signed restoring divider (one quotient bit/cycle)
//
// Computes quotient (truncated toward zero) and remainder (sign follows the
// dividend) of two signed WIDTH-bit operands. Operands are made absolute at
// accept. Each cycle the magnitude remainder/quotient pair is shifted left and
// the divisor magnitude is trial-subtracted with a WIDTH+1 bit ripple adder.
// Signs are restored in a final fix-up cycle.
//
// Optional feature macro: DIV_OVERFLOW_EXC_EN
//   defined   : MIN / -1 also raises exception at ready (result still wraps)
//   undefined : MIN / -1 wraps silently; exception only for divide-by-zero
//
// Ports
//   clock      in   1      clock, all state updates on posedge
//   resetn     in   1      asynchronous active-low reset
//   start      in   1      operation request, sampled only in IDLE
//   dividend   in   WIDTH  signed dividend, latched at accept
//   divisor    in   WIDTH  signed divisor, latched at accept
//   busy       out  1      high while iterating or fixing signs
//   ready      out  1      one-cycle pulse, results valid
//   quotient   out  WIDTH  signed quotient (held until next completion)
//   remainder  out  WIDTH  signed remainder (held until next completion)
//   exception  out  1      divide-by-zero (or optional overflow) flag
// ---------------------------------------------------------------------------

module seq_divider_rca #(
   parameter int SIZE = 33
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            cin,
   output logic [SIZE-1:0] sum,
   output logic            cout
);
   always_comb begin : ripple
      logic c;
      c   = cin;
      sum = '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
      end
      cout = c;
   end
endmodule

module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             exception
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;     // magnitude partial remainder
   logic [WIDTH-1:0] quo_q, quo_d;     // dividend magnitude shifting into quotient
   logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude (|MIN| fits unsigned)
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             exception_q, exception_d;
`ifdef DIV_OVERFLOW_EXC_EN
   logic             ovf_q, ovf_d;
`endif

   logic [WIDTH-1:0] dvd_abs, dvs_abs;
   logic [WIDTH:0]   trial;
   logic             trial_cout;
   logic             ge;

   assign dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
   assign dvs_abs = divisor[WIDTH-1]  ? -divisor  : divisor;

   // Trial subtract: {R,Q} shifted left minus |divisor|, as A + ~B + 1.
   seq_divider_rca #(.SIZE(WIDTH + 1)) u_rca (
      .a    ({rem_q, quo_q[WIDTH-1]}),
      .b    (~{1'b0, dvs_q}),
      .cin  (1'b1),
      .sum  (trial),
      .cout (trial_cout)
   );

   // Carry out means no borrow; the sign bit is then necessarily clear.
   assign ge = trial_cout & ~trial[WIDTH];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         exception_q <= 1'b0;
`ifdef DIV_OVERFLOW_EXC_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         exception_q <= exception_d;
`ifdef DIV_OVERFLOW_EXC_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      exception_d = exception_q;
`ifdef DIV_OVERFLOW_EXC_EN
      ovf_d       = ovf_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               exception_d = 1'b0;
               if (divisor == '0) begin
                  quotient_d  = '0;
                  remainder_d = dividend;
                  exception_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = dvd_abs;
                  dvs_d   = dvs_abs;
                  qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  rneg_d  = dividend[WIDTH-1];
                  cnt_d   = '0;
`ifdef DIV_OVERFLOW_EXC_EN
                  ovf_d   = (dividend == MIN_VAL) && (divisor == '1);
`endif
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            // rem_q never reaches 2^(WIDTH-1), so dropping its MSB on shift is safe.
            rem_d = ge ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], ge};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            quotient_d  = qneg_q ? -quo_q : quo_q;
            remainder_d = rneg_q ? -rem_q : rem_q;
`ifdef DIV_OVERFLOW_EXC_EN
            exception_d = ovf_q;
`endif
            state_d     = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // MIN_VAL only feeds the optional overflow detector; keep it referenced.
   logic unused_min;
   assign unused_min = ^MIN_VAL;

   assign busy      = (state_q == S_RUN) || (state_q == S_FIX);
   assign ready     = (state_q == S_DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign exception = exception_q;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider -- self-checking bench for seq_divider (WIDTH=32).
// Table-driven directed vectors, hand-written multi-cycle sequences, and
// random operands checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_divider;
   localparam int W = 32;
   localparam logic [W-1:0] MINV = 32'h8000_0000;
`ifdef DIV_OVERFLOW_EXC_EN
   localparam logic OVF = 1'b1;
`else
   localparam logic OVF = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         resetn;
   logic         start;
   logic [W-1:0] dividend, divisor;
   logic         busy, ready, exception;
   logic [W-1:0] quotient, remainder;

   int errors = 0;
   int checks = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .ready     (ready),
      .quotient  (quotient),
      .remainder (remainder),
      .exception (exception)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         e;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic [W-1:0] a, b, q, r, input logic e);
      vec_t v;
      v.a = a; v.b = b; v.q = q; v.r = r; v.e = e;
      return v;
   endfunction

   // Reference: plain signed arithmetic with the special cases stated up front.
   task automatic model(input logic [W-1:0] a, b, output logic [W-1:0] q, r, output logic e);
      logic signed [W-1:0] sa, sb;
      sa = a; sb = b;
      if (b == '0) begin
         q = '0; r = a; e = 1'b1;
      end else if (a == MINV && b == '1) begin
         q = MINV; r = '0; e = OVF;
      end else begin
         q = sa / sb; r = sa % sb; e = 1'b0;
      end
   endtask

   // Waits for ready at negedges. n = edges after accept before ready seen.
   task automatic wait_ready(input int pulse_at, output int n, output int busy_bad, output bit got);
      n = 0; busy_bad = 0; got = 0;
      while (n <= 100) begin
         @(negedge clock);
         if (n == pulse_at) begin
            start = 1'b1; dividend = 32'd9; divisor = 32'd3;
         end else if (n == pulse_at + 1) begin
            start = 1'b0;
         end
         if (ready) begin
            got = 1;
            break;
         end
         if (!busy) busy_bad++;
         n++;
      end
      start = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [W-1:0] a, b, eq, er, input logic ee);
      int  n, bb;
      bit  got;
      @(negedge clock);
      dividend = a; divisor = b; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      dividend = $urandom; divisor = $urandom;   // operands must already be latched
      check({name, " exc@accept"}, {31'b0, exception}, {31'b0, (b == '0)});
      wait_ready(-1, n, bb, got);
      check({name, " ready seen"}, {31'b0, got}, 32'd1);
      if (got) begin
         check({name, " q"}, quotient, eq);
         check({name, " r"}, remainder, er);
         check({name, " exc"}, {31'b0, exception}, {31'b0, ee});
         check({name, " latency"}, n, (b == '0) ? 32'd0 : W + 1);
         check({name, " busy while running"}, bb, 32'd0);
         check({name, " busy at ready"}, {31'b0, busy}, 32'd0);
         @(negedge clock);
         check({name, " ready one cycle"}, {31'b0, ready}, 32'd0);
      end
   endtask

   initial begin
      int           n, bb, gap;
      bit           got;
      logic [W-1:0] a, b, q, r;
      logic         e;

      tbl[0]  = mk(32'd100,     32'd7,     32'd14,      32'd2,       1'b0);
      tbl[1]  = mk(-32'sd100,   32'd7,     -32'sd14,    -32'sd2,     1'b0);
      tbl[2]  = mk(32'd100,     -32'sd7,   -32'sd14,    32'd2,       1'b0);
      tbl[3]  = mk(-32'sd100,   -32'sd7,   32'd14,      -32'sd2,     1'b0);
      tbl[4]  = mk(32'd123,     32'd0,     32'd0,       32'd123,     1'b1);
      tbl[5]  = mk(32'd8,       32'd2,     32'd4,       32'd0,       1'b0);
      tbl[6]  = mk(MINV,        32'hFFFF_FFFF, MINV,    32'd0,       OVF);
      tbl[7]  = mk(32'd0,       32'd5,     32'd0,       32'd0,       1'b0);
      tbl[8]  = mk(32'd3,       32'd10,    32'd0,       32'd3,       1'b0);
      tbl[9]  = mk(-32'sd3,     32'd10,    32'd0,       -32'sd3,     1'b0);
      tbl[10] = mk(32'h7FFF_FFFF, MINV,    32'd0,       32'h7FFF_FFFF, 1'b0);
      tbl[11] = mk(MINV,        MINV,      32'd1,       32'd0,       1'b0);
      tbl[12] = mk(MINV,        32'd2,     32'hC000_0000, 32'd0,     1'b0);
      tbl[13] = mk(-32'sd7,     32'd0,     32'd0,       -32'sd7,     1'b1);

      resetn = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      #23;
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset ready", {31'b0, ready}, 32'd0);
      check("reset exc", {31'b0, exception}, 32'd0);
      check("reset q", quotient, 32'd0);
      check("reset r", remainder, 32'd0);
      @(negedge clock);
      resetn = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].e);
      end

      // Start during RUN must be ignored; busy must stay high through FIX.
      @(negedge clock);
      dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      wait_ready(4, n, bb, got);
      check("ignored start ready", {31'b0, got}, 32'd1);
      check("ignored start q", quotient, 32'd100);
      check("ignored start r", remainder, 32'd0);
      check("ignored start busy", bb, 32'd0);
      check("ignored start latency", n, W + 1);
      @(negedge clock);
      check("ignored start no 2nd op", {31'b0, busy}, 32'd0);

      // Reset mid-operation aborts with no ready.
      @(negedge clock);
      dividend = 32'd50; divisor = 32'd5; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (10) @(negedge clock);
      resetn = 1'b0;
      #1;
      check("midreset busy", {31'b0, busy}, 32'd0);
      check("midreset ready", {31'b0, ready}, 32'd0);
      check("midreset exc", {31'b0, exception}, 32'd0);
      check("midreset q", quotient, 32'd0);
      check("midreset r", remainder, 32'd0);
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      bb = 0;
      repeat (40) begin
         @(negedge clock);
         if (ready || busy) bb++;
      end
      check("midreset no activity", bb, 32'd0);
      run_op("after reset 9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      // Start held high: back-to-back operations, one IDLE cycle between.
      @(negedge clock);
      dividend = 32'd20; divisor = 32'd3; start = 1'b1;
      wait_ready(-2, n, bb, got);
      start = 1'b1;
      check("b2b first ready", {31'b0, got}, 32'd1);
      check("b2b first q", quotient, 32'd6);
      gap = 0; got = 0;
      while (gap <= 100) begin
         @(negedge clock);
         gap++;
         if (ready) begin got = 1; break; end
      end
      start = 1'b0;
      check("b2b second ready", {31'b0, got}, 32'd1);
      check("b2b gap", gap, W + 3);
      check("b2b second r", remainder, 32'd2);

      // Random operands against the reference model.
      for (int i = 0; i < 150; i++) begin
         int sel;
         sel = $urandom_range(0, 7);
         a = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 2000)) - 1000) : 32'($urandom);
         if (sel == 0)      b = '0;
         else if (sel < 4)  b = ($urandom_range(0, 1) == 1) ? -32'($urandom_range(1, 300)) : 32'($urandom_range(1, 300));
         else if (sel == 4) b = 32'hFFFF_FFFF;
         else               b = $urandom;
         if (i % 37 == 0) a = MINV;
         model(a, b, q, r, e);
         run_op($sformatf("rand%0d %h/%h", i, a, b), a, b, q, r, e);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
